// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared types and constants for the MIPS fetch/sequencing path.
// Revision: 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int ADDR_W = 32;
    localparam int JIDX_W = 26;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0]       NOP              = 32'h0000_0000;

    typedef enum logic [0:0] {
        REQ  = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/next_pc_mux.sv
`default_nettype none
// ============================================================================
// Module  : next_pc_mux
// Brief   : Combinational next-PC selection: JR > jump > branch > sequential.
// Revision: 1.0  initial release
// ============================================================================
module next_pc_mux
    import mips_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              jr_control,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign
);

    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_branch_tgt;

    // Offset is in words; the top two bits fall off the shift and wrap naturally.
    assign w_jump_tgt   = {pc_plus4[ADDR_W-1:ADDR_W-4], jump_index, 2'b00};
    assign w_branch_tgt = pc_plus4 + {branch_offset[ADDR_W-3:0], 2'b00};

    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        if (jr_control) begin
            next_pc  = {jr_target[ADDR_W-1:2], 2'b00};
            misalign = |jr_target[1:0];
        end else if (jump) begin
            next_pc = w_jump_tgt;
        end else if (branch_taken) begin
            next_pc = w_branch_tgt;
        end
    end

endmodule : next_pc_mux
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Brief   : Two-state fetch/execute PC sequencer with JR/jump/branch redirect.
// Revision: 1.0  initial release
// ============================================================================
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              stall,
    input  logic              jr_control,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic              addr_err
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_addr_err;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_misalign;
    logic              w_leave_exec;
    logic              w_capture;

    assign pc_plus4 = r_pc + 32'd4;

    next_pc_mux u_next_pc_mux (
        .pc_plus4      (pc_plus4),
        .jr_control    (jr_control),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (w_next_pc),
        .misalign      (w_misalign)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_leave_exec = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            REQ: begin
                if (imem_ack) begin
                    w_state_nxt = EXEC;
                    w_capture   = 1'b1;
                end
            end
            EXEC: begin
                if (!stall) begin
                    w_state_nxt  = REQ;
                    w_leave_exec = 1'b1;
                end
            end
            default: w_state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_instr    <= NOP;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr_err <= w_leave_exec & w_misalign;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_leave_exec) begin
                r_pc <= w_next_pc;
            end
        end
    end

    // Gating with reset keeps the request low for the whole reset window.
    assign imem_req    = (r_state == REQ) && !reset;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == EXEC);
    assign addr_err    = r_addr_err;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_sequencer
// Brief   : Scoreboard bench for pc_sequencer with a behavioural next-PC model.
// Revision: 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic        jr;
        logic [31:0] jt;
        logic        j;
        logic [25:0] ji;
        logic        bt;
        logic [31:0] bo;
    } redir_t;

    typedef struct {
        logic [31:0] addr;
        logic        err;
    } fetch_exp_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exec_exp_t;

    logic        clk           = 1'b0;
    logic        reset         = 1'b1;
    logic        imem_ack      = 1'b0;
    logic [31:0] imem_rdata    = 32'h0;
    logic        stall         = 1'b0;
    logic        jr_control    = 1'b0;
    logic [31:0] jr_target     = 32'h0;
    logic        jump          = 1'b0;
    logic [25:0] jump_index    = 26'h0;
    logic        branch_taken  = 1'b0;
    logic [31:0] branch_offset = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        addr_err;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .stall         (stall),
        .jr_control    (jr_control),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    // Scoreboard and reference-model state
    fetch_exp_t  fetch_q[$];
    exec_exp_t   exec_q[$];
    logic [31:0] m_pc      = RST_PC;
    logic        cur_exec  = 1'b0;
    logic        nxt_exec  = 1'b0;
    logic        reset_q   = 1'b0;
    logic        mon_en    = 1'b1;
    int          n_tests   = 0;
    int          n_fail    = 0;

    always @(posedge clk) reset_q <= reset;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_next(input logic [31:0] p, input redir_t r,
                                       output logic [31:0] np, output logic err);
        logic [31:0] seq;
        seq = p + 32'd4;
        err = 1'b0;
        if (r.jr) begin
            np  = r.jt & 32'hFFFF_FFFC;
            err = (r.jt % 32'd4) != 32'd0;
        end else if (r.j) begin
            np = (seq & 32'hF000_0000) + {6'b0, r.ji} * 32'd4;
        end else if (r.bt) begin
            np = seq + r.bo * 32'd4;
        end else begin
            np = seq;
        end
    endfunction

    function automatic redir_t no_redir();
        redir_t r;
        r.jr = 1'b0; r.jt = 32'h0; r.j = 1'b0; r.ji = 26'h0; r.bt = 1'b0; r.bo = 32'h0;
        return r;
    endfunction

    function automatic redir_t rand_redir();
        redir_t r;
        r.jr = ($urandom_range(0, 3) == 0);
        r.jt = $urandom();
        r.j  = ($urandom_range(0, 3) == 0);
        r.ji = 26'($urandom());
        r.bt = ($urandom_range(0, 2) == 0);
        r.bo = 32'($urandom_range(0, 64)) - 32'd32;
        return r;
    endfunction

    // One clock of stimulus; the model advances by the same rules the design must obey.
    task automatic step(input logic ack, input logic [31:0] rd, input logic st, input redir_t r);
        logic [31:0] np;
        logic        err;
        @(posedge clk); #1;
        cur_exec      = nxt_exec;
        imem_ack      = ack;
        imem_rdata    = rd;
        stall         = st;
        jr_control    = r.jr;
        jr_target     = r.jt;
        jump          = r.j;
        jump_index    = r.ji;
        branch_taken  = r.bt;
        branch_offset = r.bo;
        if (!cur_exec) begin
            if (ack) begin
                exec_q.push_back('{rd, m_pc});
                nxt_exec = 1'b1;
            end
        end else if (!st) begin
            model_next(m_pc, r, np, err);
            fetch_q.push_back('{np, err});
            m_pc     = np;
            nxt_exec = 1'b0;
        end
    endtask

    task automatic fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i < waits; i++) step(1'b0, $urandom(), 1'b0, rand_redir());
        step(1'b1, word, 1'b0, rand_redir());
    endtask

    task automatic exec(input int stalls, input redir_t r);
        redir_t sr;
        for (int i = 0; i < stalls; i++) begin
            sr    = rand_redir();
            sr.jr = i[0];
            step(1'($urandom_range(0, 1)), $urandom(), 1'b1, sr);
        end
        step(1'($urandom_range(0, 1)), $urandom(), 1'b0, r);
    endtask

    task automatic jr_to(input logic [31:0] addr);
        redir_t r;
        r    = no_redir();
        r.jr = 1'b1;
        r.jt = addr;
        fetch(0, $urandom());
        exec(0, r);
    endtask

    task automatic do_reset(input int n, input logic ack);
        @(posedge clk); #1;
        reset      = 1'b1;
        imem_ack   = ack;
        imem_rdata = $urandom();
        stall      = 1'b0;
        fetch_q.delete();
        exec_q.delete();
        m_pc     = RST_PC;
        cur_exec = 1'b0;
        nxt_exec = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset    = 1'b0;
        imem_ack = 1'b0;
        fetch_q.push_back('{RST_PC, 1'b0});
    endtask

    // Monitor: pops expectations when the DUT presents a new fetch or instruction.
    logic        prev_req   = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] last_addr  = 32'h0;
    exec_exp_t   last_exec;
    fetch_exp_t  fe;

    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                check("rst_imem_req", imem_req, 1'b0);
                if (reset_q) begin
                    check("rst_pc", pc, RST_PC);
                    check("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
                    check("rst_instr", instr, 32'h0);
                    check("rst_instr_valid", instr_valid, 1'b0);
                    check("rst_addr_err", addr_err, 1'b0);
                end
                prev_req   = 1'b0;
                prev_valid = 1'b0;
            end else begin
                check("phase_instr_valid", instr_valid, cur_exec);
                check("phase_imem_req", imem_req, !cur_exec);
                check("imem_addr_eq_pc", imem_addr, pc);
                if (imem_req && !prev_req) begin
                    if (fetch_q.size() == 0) begin
                        check("fetch_unexpected", imem_addr, 32'hDEAD_BEEF);
                    end else begin
                        fe = fetch_q.pop_front();
                        check("fetch_addr", imem_addr, fe.addr);
                        check("fetch_addr_err", addr_err, fe.err);
                        last_addr = fe.addr;
                    end
                end else if (imem_req) begin
                    check("wait_addr_hold", imem_addr, last_addr);
                    check("wait_addr_err_low", addr_err, 1'b0);
                end
                if (instr_valid && !prev_valid) begin
                    if (exec_q.size() == 0) begin
                        check("exec_unexpected", instr, 32'hDEAD_BEEF);
                    end else begin
                        last_exec = exec_q.pop_front();
                        check("exec_instr", instr, last_exec.word);
                        check("exec_pc", pc, last_exec.pc);
                        check("exec_pc_plus4", pc_plus4, last_exec.pc + 32'd4);
                    end
                end else if (instr_valid) begin
                    check("stall_instr_hold", instr, last_exec.word);
                    check("stall_pc_hold", pc, last_exec.pc);
                end
                if (instr_valid) check("exec_addr_err_low", addr_err, 1'b0);
                prev_req   = imem_req;
                prev_valid = instr_valid;
            end
        end
    end

    initial begin
        redir_t r;

        // Reset then sequential fetch: 0x0, 0x4, 0x8, 0xC
        do_reset(2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            fetch(0, $urandom());
            exec(0, no_redir());
        end

        // Three wait states at pc=0x10
        fetch(3, 32'hA5A5_0010);
        exec(0, no_redir());

        // JR wins over jump and branch; misaligned target flags addr_err
        jr_to(32'h0000_0040);
        r = no_redir();
        r.jr = 1'b1; r.jt = 32'h0000_1002; r.j = 1'b1; r.ji = 26'h123_4567;
        r.bt = 1'b1; r.bo = 32'h0000_0010;
        fetch(0, $urandom());
        exec(0, r);

        // Backward branch 0x100 -> 0xF4
        jr_to(32'h0000_0100);
        r = no_redir(); r.bt = 1'b1; r.bo = 32'hFFFF_FFFC;
        fetch(0, $urandom());
        exec(0, r);

        // Jump region splice 0x3000_0000 -> 0x3FFF_FFFC
        jr_to(32'h3000_0000);
        r = no_redir(); r.j = 1'b1; r.ji = 26'h3FF_FFFF;
        fetch(0, $urandom());
        exec(0, r);

        // Sequential wrap 0xFFFF_FFFC -> 0x0
        jr_to(32'hFFFF_FFFC);
        fetch(1, $urandom());
        exec(0, no_redir());

        // Five-cycle stall at 0x20 with jr_control toggling, release to 0x24
        jr_to(32'h0000_0020);
        fetch(0, 32'h1234_0020);
        exec(5, no_redir());

        // Reset while a fetch at 0x80 is waiting, with a late ack during reset
        jr_to(32'h0000_0080);
        step(1'b0, $urandom(), 1'b0, no_redir());
        do_reset(2, 1'b1);
        fetch(0, $urandom());
        exec(0, no_redir());

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            fetch($urandom_range(0, 3), $urandom());
            exec($urandom_range(0, 3), rand_redir());
        end

        step(1'b0, 32'h0, 1'b0, no_redir());
        @(negedge clk); #1;
        mon_en = 1'b0;
        check("queues_drained", 32'(fetch_q.size() + exec_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MIPS datapath. It fetches instructions through a valid/ack handshake and holds each instruction for the decode/execute stage. It then computes the next PC from the redirect controls that decode produces: the JR-control bit, jump, and branch-taken. It consumes the JR-control signal and is the block that actually redirects the PC to the register target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ack  input  1  memory accepted the request; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  instruction word.
- instr  output  32  registered instruction presented to decode.
- instr_valid  output  1  instr and pc are valid for the current instruction.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32.
- stall  input  1  downstream not ready; hold the current instruction.
- jr_control  input  1  JR decoded; redirect to jr_target.
- jr_target  input  32  rs register value.
- jump  input  1  J/JAL decoded.
- jump_index  input  26  instr[25:0].
- branch_taken  input  1  branch condition true.
- branch_offset  input  32  sign-extended immediate, in words.
- addr_err  output  1  one-cycle pulse: jr_target[1:0] was nonzero when the JR redirect was taken.

## Operation
- States: REQ and EXEC.
- REQ:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack: capture instr<=imem_rdata and go to EXEC.
  - Otherwise stay in REQ with the address stable. The request is never withdrawn before ack.
- EXEC:
  - instr_valid=1.
  - imem_ack is ignored.
  - If stall=1: stay in EXEC; pc and instr are held and the redirect inputs are not sampled.
  - If stall=0: pc<=next_pc and go to REQ.
- next_pc priority, highest first:
  1. jr_control: {jr_target[31:2], 2'b00}. addr_err pulses if jr_target[1:0]!=0.
  2. jump: {pc_plus4[31:28], jump_index, 2'b00}.
  3. branch_taken: pc_plus4 + (branch_offset << 2), truncated to 32 bits.
  4. Otherwise pc_plus4.
- Simultaneous redirects resolve strictly by this priority. Lower-priority inputs are ignored.
- Arithmetic wraps modulo 2^32; 32'hFFFF_FFFC + 4 gives 0.
- Redirect inputs are meaningful only in EXEC with stall=0; they are don't-care elsewhere.

## Timing
- Reset values, applied on the first clk edge with reset=1:
  - state=REQ, pc=RESET_PC, pc_plus4=RESET_PC+4.
  - instr=0, instr_valid=0, addr_err=0.
  - imem_req=0 while reset is asserted. It rises in the first cycle after reset deasserts.
- Reset mid-operation aborts any outstanding request with no further effect. An ack arriving during reset is discarded.
- Minimum throughput: 2 cycles per instruction (REQ with same-cycle ack, then EXEC). Each wait cycle or stall cycle adds exactly one cycle.
- instr_valid is high exactly while in EXEC.
- The pc update and addr_err take effect on the edge that leaves EXEC. addr_err is high during the first REQ cycle of the redirected fetch only.
- imem_req is low in EXEC, so there are never back-to-back requests without an intervening EXEC.

## Structure
- Shared package mips_pkg holds:
  - the state enum: REQ, EXEC;
  - the RESET_PC default;
  - widths: ADDR_W=32, JIDX_W=26;
  - the NOP encoding 32'h0.
- One combinational sub-module, next_pc_mux:
  - inputs: pc_plus4, the redirect controls and targets;
  - outputs: next_pc, misalign.
- The FSM and registers stay in pc_sequencer.

## Test plan
- Reset, then sequential fetch: reset for 2 cycles, tie imem_ack=1, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high on alternate cycles; imem_req low throughout reset.
- Memory wait states: ack delayed 3 cycles at pc=0x10 -> imem_addr held at 0x10 for 4 REQ cycles; instr_valid stays low until capture.
- JR with conflict: pc=0x40, jr_control=1, jr_target=0x0000_1002, jump=1, branch_taken=1 -> next fetch at 0x1000; addr_err pulses for one cycle.
- Branch and jump arithmetic, three cases:
  - pc=0x100, branch_offset=-4 -> 0xF4;
  - pc=0x3000_0000, jump_index=0x3FF_FFFF -> 0x3FFF_FFFC;
  - pc=0xFFFF_FFFC sequential -> 0x0.
- Stall hold: 5-cycle stall in EXEC at pc=0x20 with jr_control toggling -> pc, instr, instr_valid stable; release with all redirects low -> fetch 0x24.
- Reset mid-fetch: reset asserted in REQ at pc=0x80 with ack pending -> next cycle pc=RESET_PC, imem_req=0, instr_valid=0; the late ack is ignored.
